wta_sched: RTL

Winner-take-all scheduler for the output layer of the spiking classifier. It time-multiplexes one 5-input max comparator across `P_GROUPS` groups of 5 neuron potentials, fetching one group per pass from the potential store. It tracks the running maximum and its global neuron index. It reports a single winner, or no-fire, per decision request. It sits between the neuron-potential register file and the label/spike output logic.

---
 rtl/wta_sched_if.sv | 44 ++++
 rtl/wta_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wta_sched_if.sv
// ============================================================================
// wta_sched_if : decision, potential-store and comparator bus of wta_sched
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface wta_sched_if #(
  parameter int P_WIDTH  = 19,
  parameter int P_GROUPS = 4
);
  localparam int N  = 5 * P_GROUPS;
  localparam int AW = $clog2(P_GROUPS);
  localparam int WW = $clog2(N);

  logic                   i_start;
  logic                   i_abort;
  logic [P_WIDTH-1:0]     i_thresh;
  logic                   o_busy;
  logic                   o_rd_en;
  logic [AW-1:0]          o_rd_addr;
  logic [5*P_WIDTH-1:0]   i_rd_data;
  logic [5*P_WIDTH-1:0]   o_cmp_vec;
  logic [4:0]             i_cmp_index;
  logic [P_WIDTH-1:0]     i_cmp_result;
  logic                   o_done;
  logic                   o_fire;
  logic [WW-1:0]          o_winner;
  logic [P_WIDTH-1:0]     o_max;
  logic                   o_err;

  modport master (
    input  i_start, i_abort, i_thresh, i_rd_data, i_cmp_index, i_cmp_result,
    output o_busy, o_rd_en, o_rd_addr, o_cmp_vec, o_done, o_fire, o_winner,
           o_max, o_err
  );

  modport slave (
    output i_start, i_abort, i_thresh, i_rd_data, i_cmp_index, i_cmp_result,
    input  o_busy, o_rd_en, o_rd_addr, o_cmp_vec, o_done, o_fire, o_winner,
           o_max, o_err
  );
endinterface

`default_nettype wire

// File: rtl/wta_sched.sv
// ============================================================================
// wta_sched : winner-take-all scheduler sharing one 5-input max comparator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module wta_sched #(
  parameter int P_WIDTH  = 19,
  parameter int P_GROUPS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  wta_sched_if.master bus
);
  localparam int N  = 5 * P_GROUPS;
  localparam int AW = $clog2(P_GROUPS);
  localparam int WW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        g_q, g_d;
  logic [P_WIDTH-1:0]   thresh_q, thresh_d;
  logic [P_WIDTH-1:0]   best_q, best_d;
  logic [WW-1:0]        idx_q, idx_d;
  logic                 have_q, have_d;
  logic [5*P_WIDTH-1:0] cmp_vec_q, cmp_vec_d;
  logic                 fire_q, fire_d;
  logic [WW-1:0]        winner_q, winner_d;
  logic [P_WIDTH-1:0]   max_q, max_d;
  logic                 err_q, err_d;

  logic [2:0]           w_lane;
  logic                 w_any;
  logic                 w_onehot;
  logic                 w_take;
  logic                 w_have_nx;
  logic [P_WIDTH-1:0]   w_best_nx;
  logic [WW-1:0]        w_idx_nx;
  logic [WW-1:0]        w_cand_idx;
  logic                 w_last;

  always_comb begin
    w_lane = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (bus.i_cmp_index[k]) w_lane = 3'(k);
    end
  end

  // A candidate replaces the running best only on strict greater-than, so earlier groups win ties.
  always_comb begin
    w_any      = |bus.i_cmp_index;
    w_onehot   = w_any && ((bus.i_cmp_index & (bus.i_cmp_index - 5'd1)) == 5'd0);
    w_cand_idx = WW'((5 * int'(g_q)) + int'(w_lane));
    w_take     = w_onehot && (!have_q || (bus.i_cmp_result > best_q));
    w_have_nx  = have_q | w_take;
    w_best_nx  = w_take ? bus.i_cmp_result : best_q;
    w_idx_nx   = w_take ? w_cand_idx : idx_q;
    w_last     = (g_q == AW'(P_GROUPS - 1));
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    thresh_d  = thresh_q;
    best_d    = best_q;
    idx_d     = idx_q;
    have_d    = have_q;
    cmp_vec_d = cmp_vec_q;
    fire_d    = fire_q;
    winner_d  = winner_q;
    max_d     = max_q;
    err_d     = err_q;

    if ((state_q != IDLE) && bus.i_abort) begin
      state_d  = IDLE;
      fire_d   = 1'b0;
      winner_d = '0;
      max_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            state_d  = FETCH;
            g_d      = '0;
            best_d   = '0;
            idx_d    = '0;
            have_d   = 1'b0;
            thresh_d = bus.i_thresh;
            fire_d   = 1'b0;
            winner_d = '0;
            max_d    = '0;
            err_d    = 1'b0;
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          cmp_vec_d = bus.i_rd_data;
          state_d   = CMP;
        end
        CMP: begin
          best_d = w_best_nx;
          idx_d  = w_idx_nx;
          have_d = w_have_nx;
          if (w_any && !w_onehot) err_d = 1'b1;
          if (w_last) begin
            // Results are decided from the post-update best so the last group counts.
            state_d  = DONE;
            fire_d   = w_have_nx && (w_best_nx >= thresh_q);
            winner_d = (w_have_nx && (w_best_nx >= thresh_q)) ? w_idx_nx : '0;
            max_d    = w_have_nx ? w_best_nx : '0;
          end else begin
            g_d     = g_q + AW'(1);
            state_d = FETCH;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      thresh_q  <= '0;
      best_q    <= '0;
      idx_q     <= '0;
      have_q    <= 1'b0;
      cmp_vec_q <= '0;
      fire_q    <= 1'b0;
      winner_q  <= '0;
      max_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      thresh_q  <= thresh_d;
      best_q    <= best_d;
      idx_q     <= idx_d;
      have_q    <= have_d;
      cmp_vec_q <= cmp_vec_d;
      fire_q    <= fire_d;
      winner_q  <= winner_d;
      max_q     <= max_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_rd_en   = (state_q == FETCH);
  assign bus.o_rd_addr = (state_q == FETCH) ? g_q : '0;
  assign bus.o_cmp_vec = cmp_vec_q;
  assign bus.o_done    = (state_q == DONE);
  assign bus.o_fire    = fire_q;
  assign bus.o_winner  = winner_q;
  assign bus.o_max     = max_q;
  assign bus.o_err     = err_q;

endmodule

`default_nettype wire
